alu_operand_skid: RTL and testbench
===================================

Name: alu_operand_skid

Overview:
- Registered issue stage directly upstream of the ALU and shifter datapath (add/sub/and/or/sll/sra).
- Accepts one operation per cycle from decode over a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Presents registered operands, shift amount and one-hot decoded op-selects to the ALU.
- Breaks the ready path so that backpressure from the ALU never reaches decode combinationally.

Parameters:
- DATA_W, 32, operand width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).
- CNT_W, 16, width of the saturating issued-operation counter.

Ports:
- clock  input  1  single clock domain; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  stage can accept this cycle; driven directly from a flop.
- in_opcode  input  5  ALU opcode.
- in_shamt  input  SHAMT_W  shift amount.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- out_valid  output  1  operation presented to the ALU.
- out_ready  input  1  ALU consumes this cycle.
- out_a  output  DATA_W  registered operand A.
- out_b  output  DATA_W  registered operand B.
- out_opcode  output  5  registered opcode.
- out_shamt  output  SHAMT_W  registered shift amount; forced to 0 for non-shift ops.
- out_sel  output  6  one-hot {sra, sll, or, and, sub, add}; all zero when the opcode is illegal.
- out_illegal  output  1  registered opcode is outside 00000..00101.
- issued_cnt  output  CNT_W  count of out fires; saturates at all-ones.

Behaviour:
- Reset is asynchronous, active-low on reset_n; all state is clocked on the rising edge of clock.
- Reset values: in_ready=1, out_valid=0, skid slot empty, issued_cnt=0, all payload outputs 0 (out_sel=0, out_illegal=0).
- Handshake definitions:
  - accept = in_valid & in_ready.
  - fire = out_valid & out_ready.
  - Payload is sampled only on accept.
  - out_* is stable while out_valid=1 and out_ready=0.
- Structure:
  - Main register drives out_*.
  - Skid register holds one overflow entry.
  - in_ready = ~skid_valid, registered.
- State machine (occupancy):
  - EMPTY: accept -> ONE (main loads input).
  - ONE, accept & fire -> ONE (main loads input).
  - ONE, accept & ~fire -> FULL (skid loads input, in_ready falls next cycle).
  - ONE, ~accept & fire -> EMPTY.
  - ONE, neither -> ONE (hold).
  - FULL: no accept possible (in_ready=0); fire -> ONE (main loads skid, in_ready rises next cycle); otherwise hold.
- Ordering is strictly FIFO; no operation is dropped or duplicated.
- Latency: accept in cycle N -> out_valid in N+1 if the stage was EMPTY or firing in N.
- Throughput: 1 op per cycle when out_ready stays high.
- Decode is performed before storage, so main and skid both hold decoded fields:
  - 00000 -> add.
  - 00001 -> sub.
  - 00010 -> and.
  - 00011 -> or.
  - 00100 -> sll.
  - 00101 -> sra.
  - Any other opcode: out_sel=0 and out_illegal=1; the entry still passes through the handshake normally.
- out_shamt = in_shamt for sll/sra, otherwise 0.
- When out_valid=0, the payload outputs hold their last values (no clearing).
- issued_cnt increments by 1 on each fire and sticks at 2^CNT_W-1.
- Reset asserted mid-operation: buffered entries are discarded immediately (asynchronously); no partial state survives.
- in_valid while in_ready=0: ignored; upstream must hold its payload.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SRA;
  - one-hot select bit indices;
  - DATA_W/SHAMT_W defaults.
- One natural sub-module: alu_op_decode, combinational opcode -> {sel, illegal, shamt_en}, reusable by the ALU top.
- The skid/occupancy logic stays in alu_operand_skid.

Test Plan:
- Reset, then in_valid=1 with opcode 00101, a=0x8000_0010, shamt=4, out_ready=1 -> next cycle out_valid=1, out_sel=100000, out_shamt=4, out_a=0x8000_0010, issued_cnt=1 after the fire.
- Streaming: 8 back-to-back ops, out_ready=1 throughout -> 8 fires in consecutive cycles, in order, in_ready never drops.
- Backpressure: out_ready=0, 2 accepts -> in_ready=0 from the 3rd cycle; out_ready=1 for 1 cycle -> first op fires, in_ready=1 next cycle, second op follows; no loss or reorder.
- Opcode 00010 with shamt=7 -> out_shamt=0, out_sel=000100; opcode 01111 -> out_illegal=1, out_sel=0, and it still fires normally.
- Assert reset_n=0 asynchronously mid-cycle while FULL -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
- Preload issued_cnt near the limit (or CNT_W=4, 20 fires) -> issued_cnt stays at 0xF.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path: opcode encodings, one-hot
// select bit positions, default datapath widths and the skid-buffer
// occupancy encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SHAMT_W_DEF = 5;   // must equal $clog2(DATA_W)
    localparam int OPC_W       = 5;
    localparam int SEL_W       = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;

    // Bit positions inside the one-hot select {sra, sll, or, and, sub, add}.
    localparam int SEL_ADD = 0;
    localparam int SEL_SUB = 1;
    localparam int SEL_AND = 2;
    localparam int SEL_OR  = 3;
    localparam int SEL_SLL = 4;
    localparam int SEL_SRA = 5;

    // Number of valid entries held by the stage (main + skid).
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/alu_operand_skid_if.sv
// ---------------------------------------------------------------------------
// alu_operand_skid_if
// Decode-side and ALU-side handshake bundle of the operand issue stage.
//   slave  : view of the issue stage (consumes in_*, produces out_*)
//   master : view of the environment (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface alu_operand_skid_if
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [OPC_W-1:0]   in_opcode;
    logic [SHAMT_W-1:0] in_shamt;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_a;
    logic [DATA_W-1:0]  out_b;
    logic [OPC_W-1:0]   out_opcode;
    logic [SHAMT_W-1:0] out_shamt;
    logic [SEL_W-1:0]   out_sel;
    logic               out_illegal;

    modport slave (
        input  in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_opcode, out_shamt,
               out_sel, out_illegal
    );

    modport master (
        output in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_opcode, out_shamt,
               out_sel, out_illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational opcode decoder shared by the issue stage and the ALU top.
//   opcode   : 5-bit ALU opcode
//   sel      : one-hot {sra, sll, or, and, sub, add}; zero for illegal codes
//   illegal  : opcode outside 00000..00101
//   shamt_en : op consumes the shift amount (sll / sra)
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic [SEL_W-1:0] sel,
    output logic             illegal,
    output logic             shamt_en
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statement can leave one unassigned and infer a latch.
        sel     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  sel[SEL_ADD] = 1'b1;
            OP_SUB:  sel[SEL_SUB] = 1'b1;
            OP_AND:  sel[SEL_AND] = 1'b1;
            OP_OR:   sel[SEL_OR]  = 1'b1;
            OP_SLL:  sel[SEL_SLL] = 1'b1;
            OP_SRA:  sel[SEL_SRA] = 1'b1;
            default: illegal      = 1'b1;
        endcase
        shamt_en = sel[SEL_SLL] | sel[SEL_SRA];
    end

endmodule

// File: rtl/alu_operand_skid.sv
// ---------------------------------------------------------------------------
// alu_operand_skid
// Registered issue stage in front of the ALU/shifter. Accepts one decoded
// operation per cycle into a 2-entry skid buffer (main + skid) and presents
// the main entry to the ALU. in_ready comes straight from a flop, so ALU
// backpressure never reaches decode combinationally.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus            : decode-side in_* and ALU-side out_* handshake/payload
//   issued_cnt     : saturating count of out fires
// SHAMT_W is expected to equal $clog2(DATA_W).
// ---------------------------------------------------------------------------
module alu_operand_skid
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_operand_skid_if.slave    bus,
    output logic [CNT_W-1:0]     issued_cnt
);

    // Entries are stored already decoded so the ALU sees registered selects.
    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [OPC_W-1:0]   opcode;
        logic [SHAMT_W-1:0] shamt;
        logic [SEL_W-1:0]   sel;
        logic               illegal;
    } entry_t;

    occ_t       state;
    entry_t     main_q;
    entry_t     skid_q;
    entry_t     in_entry;
    logic       in_ready_q;
    logic [SEL_W-1:0] dec_sel;
    logic       dec_illegal;
    logic       dec_shamt_en;
    logic       accept;
    logic       fire;

    alu_op_decode u_decode (
        .opcode   (bus.in_opcode),
        .sel      (dec_sel),
        .illegal  (dec_illegal),
        .shamt_en (dec_shamt_en)
    );

    always_comb begin
        in_entry.a       = bus.in_a;
        in_entry.b       = bus.in_b;
        in_entry.opcode  = bus.in_opcode;
        in_entry.shamt   = dec_shamt_en ? bus.in_shamt : '0;
        in_entry.sel     = dec_sel;
        in_entry.illegal = dec_illegal;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign fire   = bus.out_valid & bus.out_ready;

    // in_ready_q mirrors "skid slot free"; it is cleared in the same edge
    // that fills the skid and set in the same edge that drains it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the payload registers are reset too, not just the
            // valid state, so the outputs are deterministic out of reset.
            state      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
            issued_cnt <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && fire) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q     <= in_entry;
                        in_ready_q <= 1'b0;
                        state      <= OCC_FULL;
                    end else if (fire) begin
                        state <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (fire) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= OCC_ONE;
                    end
                end
                default: begin
                    state      <= OCC_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase

            if (fire && (issued_cnt != '1)) begin
                issued_cnt <= issued_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state != OCC_EMPTY);
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_shamt   = main_q.shamt;
    assign bus.out_sel     = main_q.sel;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_operand_skid.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_skid
// Directed bench for alu_operand_skid: one CNT_W=16 instance for the
// functional scenarios and one CNT_W=4 instance for counter saturation.
// ---------------------------------------------------------------------------
module tb_alu_operand_skid;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    alu_operand_skid_if #(.DATA_W(32), .SHAMT_W(5)) bus  ();
    alu_operand_skid_if #(.DATA_W(32), .SHAMT_W(5)) bus4 ();

    logic [15:0] cnt;
    logic [3:0]  cnt4;

    alu_operand_skid #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .issued_cnt (cnt)
    );

    alu_operand_skid #(.DATA_W(32), .SHAMT_W(5), .CNT_W(4)) dut4 (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus4),
        .issued_cnt (cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Fire log of the main instance, sampled on the rising edge (pre-update).
    typedef struct {
        logic [31:0] a;
        logic [4:0]  op;
        logic [5:0]  sel;
        logic        ill;
        int          cyc;
    } rec_t;

    rec_t fired[$];
    int   cyc = 0;

    always @(posedge clock) begin
        cyc++;
        if (reset_n && bus.out_valid && bus.out_ready)
            fired.push_back('{a: bus.out_a, op: bus.out_opcode, sel: bus.out_sel,
                              ill: bus.out_illegal, cyc: cyc});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_shamt  = sh;
        bus.in_a      = a;
        bus.in_b      = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        bus.out_ready  = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_opcode = 5'd0;
        bus4.in_shamt  = 5'd0;
        bus4.in_a      = 32'd0;
        bus4.in_b      = 32'd0;
        bus4.out_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_sel !== 6'b0 || bus.out_illegal !== 1'b0 || bus.out_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_payload: sel=%b ill=%b a=%h want 0/0/0",
                     bus.out_sel, bus.out_illegal, bus.out_a);
        end
        checks++;
        if (cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_first_op();
        fired.delete();
        bus.out_ready = 1'b1;
        drive(1'b1, 5'b00101, 5'd4, 32'h8000_0010, 32'h0000_0003);
        tick();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 6'b100000 || bus.out_shamt !== 5'd4 ||
            bus.out_a !== 32'h8000_0010 || bus.out_b !== 32'h0000_0003 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL first_sra: v=%b sel=%b sh=%0d a=%h b=%h ill=%b want 1/100000/4/80000010/00000003/0",
                     bus.out_valid, bus.out_sel, bus.out_shamt, bus.out_a, bus.out_b, bus.out_illegal);
        end
        tick();
        checks++;
        if (cnt !== 16'd1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL first_fire: cnt=%0d v=%b want 1/0", cnt, bus.out_valid);
        end
        checks++;
        if (bus.out_a !== 32'h8000_0010 || bus.out_sel !== 6'b100000) begin
            errors++; $display("FAIL payload_hold: a=%h sel=%b want 80000010/100000", bus.out_a, bus.out_sel);
        end
    endtask

    task automatic test_decode();
        drive(1'b1, 5'b00010, 5'd7, 32'h1234_5678, 32'h0F0F_0F0F);
        tick();
        drive(1'b1, 5'b01111, 5'd9, 32'hDEAD_BEEF, 32'h0);
        checks++;
        if (bus.out_shamt !== 5'd0 || bus.out_sel !== 6'b000100 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL decode_and: sh=%0d sel=%b ill=%b want 0/000100/0",
                     bus.out_shamt, bus.out_sel, bus.out_illegal);
        end
        tick();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_sel !== 6'b0 ||
            bus.out_opcode !== 5'b01111 || bus.out_shamt !== 5'd0 || bus.out_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL decode_illegal: v=%b ill=%b sel=%b op=%b sh=%0d a=%h want 1/1/0/01111/0/deadbeef",
                     bus.out_valid, bus.out_illegal, bus.out_sel, bus.out_opcode, bus.out_shamt, bus.out_a);
        end
        tick();
        checks++;
        if (cnt !== 16'd3 || bus.out_valid !== 1'b0 || fired.size() != 3) begin
            errors++;
            $display("FAIL illegal_fires: cnt=%0d v=%b fires=%0d want 3/0/3", cnt, bus.out_valid, fired.size());
        end
    endtask

    task automatic test_back_to_back();
        int ready_drops = 0;
        int bad = 0;
        fired.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i % 6), 5'd1, 32'h100 + 32'(i), 32'(i));
            tick();
            if (bus.in_ready !== 1'b1) ready_drops++;
        end
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        checks++;
        if (ready_drops != 0) begin
            errors++; $display("FAIL stream_in_ready: drops=%0d want 0", ready_drops);
        end
        checks++;
        if (fired.size() != 8) begin
            errors++; $display("FAIL stream_count: got %0d want 8", fired.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (fired[i].a !== 32'h100 + 32'(i) || fired[i].op !== 5'(i % 6) ||
                    (i > 0 && fired[i].cyc != fired[i-1].cyc + 1)) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stream_order: bad entries=%0d want 0", bad);
        end
        checks++;
        if (cnt !== 16'd11) begin
            errors++; $display("FAIL stream_cnt: got %0d want 11", cnt);
        end
    endtask

    task automatic test_backpressure();
        fired.delete();
        bus.out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 32'hA1, 32'h1);
        tick();
        drive(1'b1, 5'd1, 5'd0, 32'hB2, 32'h2);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_one: got %b want 1", bus.in_ready);
        end
        tick();
        drive(1'b1, 5'd3, 5'd0, 32'hC3, 32'h3);   // held until accepted
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_a !== 32'hA1) begin
            errors++; $display("FAIL bp_full: ready=%b a=%h want 0/a1", bus.in_ready, bus.out_a);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_a !== 32'hA1 || bus.out_valid !== 1'b1 || fired.size() != 0) begin
            errors++;
            $display("FAIL bp_stable: ready=%b a=%h v=%b fires=%0d want 0/a1/1/0",
                     bus.in_ready, bus.out_a, bus.out_valid, fired.size());
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_a !== 32'hB2 || bus.out_sel !== 6'b000010) begin
            errors++;
            $display("FAIL bp_drain: ready=%b a=%h sel=%b want 1/b2/000010", bus.in_ready, bus.out_a, bus.out_sel);
        end
        tick();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_a !== 32'hB2) begin
            errors++; $display("FAIL bp_refill: ready=%b a=%h want 0/b2", bus.in_ready, bus.out_a);
        end
        bus.out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (fired.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d want 3", fired.size());
        end else if (fired[0].a !== 32'hA1 || fired[1].a !== 32'hB2 || fired[2].a !== 32'hC3) begin
            errors++;
            $display("FAIL bp_order: got %h %h %h want a1 b2 c3", fired[0].a, fired[1].a, fired[2].a);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || cnt !== 16'd14) begin
            errors++; $display("FAIL bp_end: v=%b cnt=%0d want 0/14", bus.out_valid, cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 32'h55, 32'h0);
        tick();
        drive(1'b1, 5'd1, 5'd0, 32'h66, 32'h0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL ar_setup_full: ready=%b v=%b want 0/1", bus.in_ready, bus.out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || cnt !== 16'd0 || bus.out_a !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: v=%b ready=%b cnt=%0d a=%h want 0/1/0/0",
                     bus.out_valid, bus.in_ready, cnt, bus.out_a);
        end
        tick();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || cnt !== 16'd0) begin
            errors++; $display("FAIL ar_nothing_survives: v=%b cnt=%0d want 0/0", bus.out_valid, cnt);
        end
    endtask

    task automatic test_saturation();
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus4.in_valid  = 1'b1;
            bus4.in_opcode = 5'd0;
            bus4.in_a      = 32'(i);
            tick();
            if (i == 10) begin
                checks++;
                if (cnt4 !== 4'd10) begin
                    errors++; $display("FAIL sat_mid: got %0d want 10", cnt4);
                end
            end
        end
        bus4.in_valid = 1'b0;
        tick();
        checks++;
        if (cnt4 !== 4'hF) begin
            errors++; $display("FAIL sat_hold: got %h want f", cnt4);
        end
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
